// File: rtl/btn_cmd_conditioner.sv
// btn_cmd_conditioner: turns four raw, bouncing pushbuttons into one-clock
// command pulses for the calculator control FSM.
//   btn_lane            - per-button 2-flop synchronizer + debouncer
//   btn_cmd_conditioner - lane array + chord FSM (or edge detector)
// Build option: BTN_CHORD_EN
//   defined   - buttons held together form a chord, emitted once on full release
//   undefined - each debounced rising edge pulses immediately, releases are silent

module btn_lane #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic held
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_pipe;
  logic [CNT_W-1:0] cnt;
  logic             sync;

  assign sync = sync_pipe[1];

  // two-flop synchronizer for the asynchronous button level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[0], raw};
  end

  // accept a new level only after DEBOUNCE_CYCLES consecutive mismatched samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      held <= 1'b0;
    end else if (sync == held) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      held <= ~held;
      cnt  <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

module btn_cmd_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btns_raw,
  output logic [3:0] btns,
  output logic [3:0] held,
  output logic       busy
);
  localparam int NUM_LANES = 4;

  btn_lane #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_lane [NUM_LANES-1:0] (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (btns_raw),
    .held (held)
  );

`ifdef BTN_CHORD_EN
  typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

  state_t               state, state_nxt;
  logic [NUM_LANES-1:0] chord, chord_nxt, btns_nxt;

  // chord FSM: accumulate every button seen while any is held, emit on full release
  always_comb begin
    state_nxt = state;
    chord_nxt = chord;
    btns_nxt  = '0;
    case (state)
      IDLE: begin
        chord_nxt = '0;
        if (held != '0) begin
          state_nxt = COLLECT;
          chord_nxt = held;
        end
      end
      COLLECT: begin
        chord_nxt = chord | held;
        if (held == '0) begin
          state_nxt = EMIT;
          btns_nxt  = chord;   // registered, so it is visible during EMIT
        end
      end
      EMIT: begin
        state_nxt = IDLE;
        chord_nxt = '0;
      end
      default: begin
        state_nxt = IDLE;
        chord_nxt = '0;
      end
    endcase
  end

  // FSM state, chord and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      chord <= '0;
      btns  <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      chord <= chord_nxt;
      btns  <= btns_nxt;
      busy  <= (state_nxt == COLLECT);
    end
  end
`else
  logic [NUM_LANES-1:0] held_q;

  assign busy = 1'b0;

  // pulse each newly pressed button for one clock; releases are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q <= '0;
      btns   <= '0;
    end else begin
      held_q <= held;
      btns   <= held & ~held_q;
    end
  end
`endif
endmodule
